mac_cla_accumulator: RTL and testbench
======================================

// Module: mac_cla_accumulator
// PURPOSE
//  Signed accumulator that consumes partial products from the subarray MAC datapath and sums a burst
//  of them into one result. The adder is built from per-bit CLA cells (Gi=a&b, Pi=a|b, SO=a^b^cin)
//  with 4-bit group carry lookahead. Valid/ready on both sides; sits downstream of the multiplier
//  array and upstream of the result writeback.
// PARAMETERS
//  IN_W   16  width of signed two's-complement input operand
//  ACC_W  24  accumulator/result width (must be >= IN_W; must be a multiple of 4)
//  CNT_W  8   width of beat counter
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      in_data/in_last valid
//  in_ready   out  1      block accepts a beat this cycle
//  in_data    in   IN_W   signed partial product
//  in_last    in   1      marks final beat of the burst
//  out_valid  out  1      result valid; held until accepted
//  out_ready  in   1      downstream accepts result
//  out_sum    out  ACC_W  accumulated signed sum
//  out_ovf    out  1      sticky signed overflow seen during the burst
//  out_count  out  CNT_W  beats in the burst, saturating at 2^CNT_W-1
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=ACC, acc=0, count=0, ovf=0, out_valid=0, out_sum=0, out_ovf=0,
//    out_count=0; in_ready=1 once reset is released. Reset mid-burst discards the partial sum.
//  - Beat accepted when in_valid&in_ready (sampled on the rising edge of clk).
//  - States: ACC (in_ready=1, out_valid=0); HOLD (in_ready=0, out_valid=1).
//  - ACC, accepted beat, in_last=0: acc<=acc+sext(in_data); count<=sat(count+1);
//    ovf<=ovf|signed_ovf. Stay in ACC.
//  - ACC, accepted beat, in_last=1: out_sum<=acc+sext(in_data); out_ovf<=ovf|signed_ovf;
//    out_count<=sat(count+1); acc,count,ovf<=0; go to HOLD.
//    Latency: out_valid=1 in the cycle after the last beat is accepted.
//  - HOLD: out_sum/out_ovf/out_count held stable while out_ready=0. Do not accept input.
//  - HOLD & out_ready: out_valid<=0; go to ACC. A new beat is accepted no earlier than the next cycle.
//    No bypass: at most one burst is in flight.
//  - Adder: operand b=sext(in_data) to ACC_W. Each bit i: Gi=a&b, Pi=a|b. Carries within a 4-bit
//    group: c[i+1]=Gi|(Pi&c[i]), expanded in lookahead form. Group signals: GG=G3|P3G2|P3P2G1|P3P2P1G0,
//    GP=P3P2P1P0, rippled between groups. cin=0. Sum wraps modulo 2^ACC_W.
//  - signed_ovf = (a[MSB]==b[MSB]) & (sum[MSB]!=a[MSB]). The sum still wraps; overflow only sets the flag.
//  - count saturates: at 2^CNT_W-1 it stays there. The sum keeps accumulating.
//  - in_valid=0 in ACC: no state change, including mid-burst gaps of any length.
//  - in_data/in_last are ignored while in HOLD, even if in_valid=1.
// TESTING
//  1 Reset: assert rst_n=0 asynchronously mid-cycle -> out_valid=0, out_sum=0, out_ovf=0, out_count=0
//    immediately; after release, in_ready=1.
//  2 Burst 3,5,-2 (last on -2), out_ready=1 -> one cycle after last: out_valid=1, out_sum=6,
//    out_count=3, out_ovf=0. Next cycle out_valid=0, in_ready=1.
//  3 Backpressure: burst 10,20 (last), out_ready=0 for 4 cycles with in_valid=1 and in_data=7
//    -> in_ready=0, out_sum=30 stable; then out_ready=1 -> the next burst starts fresh (first sum=7).
//  4 Overflow, ACC_W=16, IN_W=16: beats 16'h7FFF, 16'h0001 (last) -> out_sum=16'h8000, out_ovf=1;
//    the following burst 1 (last) -> out_ovf=0.
//  5 Single-beat burst in_data=16'hFFFF with in_last=1 -> out_sum=24'hFFFFFF, out_count=1.
//  6 Reset mid-burst after beats 100,200 -> acc cleared; new burst 1,1 (last) -> out_sum=2, out_count=2.
//    Also: 300 beats of +1 with CNT_W=8 -> out_count=255, out_sum=300.

Source files
------------

// File: rtl/mac_cla_accumulator.sv
// Signed burst accumulator for MAC partial products: a 4-bit-group carry-lookahead adder feeds a
// two-state ACC/HOLD handshake controller with sticky overflow and a saturating beat count.
module mac_cla_accumulator #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned ACC_W = 24,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

    localparam int unsigned NGRP = ACC_W / 4;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             ovf;

    logic [ACC_W-1:0] b_ext;
    logic [ACC_W-1:0] gen, prop, carry, sum;
    logic [NGRP-1:0]  grp_cin;
    logic             signed_ovf;
    logic [CNT_W-1:0] count_inc;
    logic             beat;

    // Sign-extend the partial product to the accumulator width
    assign b_ext = ACC_W'($signed(in_data));

    assign gen  = acc & b_ext;
    assign prop = acc | b_ext;
    assign grp_cin[0] = 1'b0;

    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        localparam int unsigned B = 4 * k;

        assign carry[B]   = grp_cin[k];
        assign carry[B+1] = gen[B] | (prop[B] & grp_cin[k]);
        assign carry[B+2] = gen[B+1] | (prop[B+1] & gen[B])
                          | (prop[B+1] & prop[B] & grp_cin[k]);
        assign carry[B+3] = gen[B+2] | (prop[B+2] & gen[B+1])
                          | (prop[B+2] & prop[B+1] & gen[B])
                          | (prop[B+2] & prop[B+1] & prop[B] & grp_cin[k]);

        // The top group's carry-out is discarded: the sum wraps modulo 2^ACC_W
        if (k < NGRP - 1) begin : g_link
            logic grp_g, grp_p;
            assign grp_g = gen[B+3] | (prop[B+3] & gen[B+2])
                         | (prop[B+3] & prop[B+2] & gen[B+1])
                         | (prop[B+3] & prop[B+2] & prop[B+1] & gen[B]);
            assign grp_p = &prop[B+3:B];
            assign grp_cin[k+1] = grp_g | (grp_p & grp_cin[k]);
        end
    end

    // a^b expressed from the cell's own P and G so every cell output is used
    assign sum = (prop & ~gen) ^ carry;

    assign signed_ovf = (acc[ACC_W-1] == b_ext[ACC_W-1]) & (sum[ACC_W-1] != acc[ACC_W-1]);
    assign count_inc  = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);
    assign beat       = in_valid & in_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ACC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACC:  if (beat && in_last) state_nxt = ST_HOLD;
            ST_HOLD: if (out_ready)       state_nxt = ST_ACC;
            default: state_nxt = ST_ACC;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_ACC:  in_ready  = 1'b1;
            ST_HOLD: out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Accumulator and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
            out_count <= '0;
        end else if (beat) begin
            if (in_last) begin
                out_sum   <= sum;
                out_ovf   <= ovf | signed_ovf;
                out_count <= count_inc;
                acc       <= '0;
                count     <= '0;
                ovf       <= 1'b0;
            end else begin
                acc   <= sum;
                count <= count_inc;
                ovf   <= ovf | signed_ovf;
            end
        end
    end

endmodule

// File: tb/tb_mac_cla_accumulator.sv
// Directed bench for mac_cla_accumulator: a 24-bit and a 16-bit accumulator share one stimulus stream.
module tb_mac_cla_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready, out_valid, out_ovf;
    logic [23:0] out_sum;
    logic [7:0]  out_count;

    logic        in_ready_16, out_valid_16, out_ovf_16;
    logic [15:0] out_sum_16;
    logic [7:0]  out_count_16;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mac_cla_accumulator #(.IN_W(16), .ACC_W(24), .CNT_W(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    mac_cla_accumulator #(.IN_W(16), .ACC_W(16), .CNT_W(8)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_16),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid_16),
        .out_ready (out_ready),
        .out_sum   (out_sum_16),
        .out_ovf   (out_ovf_16),
        .out_count (out_count_16)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Present one beat right after a rising edge and hold it until accepted
    task automatic send_beat(input logic [15:0] d, input logic l);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum",   32'(out_sum),   32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick(1);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Test 1: asynchronous reset mid-cycle while a result is held
        out_ready = 1'b0;
        send_beat(16'd5, 1'b1);
        check("t1_pre_valid", 32'(out_valid), 32'd1);
        check("t1_pre_sum",   32'(out_sum),   32'd5);
        #3 rst_n = 1'b0;
        #1;
        check("t1_valid", 32'(out_valid), 32'd0);
        check("t1_sum",   32'(out_sum),   32'd0);
        check("t1_ovf",   32'(out_ovf),   32'd0);
        check("t1_count", 32'(out_count), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        tick(1);
        check("t1_in_ready", 32'(in_ready), 32'd1);

        // Test 2: 3,5,-2 with an idle gap mid-burst
        send_beat(16'd3, 1'b0);
        tick(3);
        check("t2_gap_ready", 32'(in_ready),  32'd1);
        check("t2_gap_valid", 32'(out_valid), 32'd0);
        send_beat(16'd5, 1'b0);
        send_beat(16'hFFFE, 1'b1);
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_sum",   32'(out_sum),   32'd6);
        check("t2_count", 32'(out_count), 32'd3);
        check("t2_ovf",   32'(out_ovf),   32'd0);
        check("t2_sum16", 32'(out_sum_16), 32'd6);
        tick(1);
        check("t2_valid_drop", 32'(out_valid), 32'd0);
        check("t2_ready_back", 32'(in_ready),  32'd1);

        // Test 3: backpressure, input ignored while holding
        out_ready = 1'b0;
        send_beat(16'd10, 1'b0);
        send_beat(16'd20, 1'b1);
        in_valid = 1'b1;
        in_data  = 16'd7;
        for (int i = 0; i < 4; i++) begin
            check("t3_in_ready", 32'(in_ready),  32'd0);
            check("t3_valid",    32'(out_valid), 32'd1);
            check("t3_sum",      32'(out_sum),   32'd30);
            tick(1);
        end
        check("t3_count", 32'(out_count), 32'd2);
        out_ready = 1'b1;
        tick(1);
        check("t3_release", 32'(out_valid), 32'd0);
        send_beat(16'd7, 1'b1);
        check("t3_fresh_sum",   32'(out_sum),   32'd7);
        check("t3_fresh_count", 32'(out_count), 32'd1);
        tick(1);

        // Test 4: signed overflow on the 16-bit accumulator, none on the 24-bit one
        send_beat(16'h7FFF, 1'b0);
        send_beat(16'h0001, 1'b1);
        check("t4_sum16", 32'(out_sum_16), 32'h8000);
        check("t4_ovf16", 32'(out_ovf_16), 32'd1);
        check("t4_sum24", 32'(out_sum),    32'h008000);
        check("t4_ovf24", 32'(out_ovf),    32'd0);
        tick(1);
        send_beat(16'h0001, 1'b1);
        check("t4_next_ovf16", 32'(out_ovf_16), 32'd0);
        check("t4_next_sum16", 32'(out_sum_16), 32'd1);
        tick(1);

        // Test 4b: negative overflow 0x8000 + 0xFFFF on 16 bits
        send_beat(16'h8000, 1'b0);
        send_beat(16'hFFFF, 1'b1);
        check("t4b_sum16", 32'(out_sum_16), 32'h7FFF);
        check("t4b_ovf16", 32'(out_ovf_16), 32'd1);
        check("t4b_sum24", 32'(out_sum),    32'hFF7FFF);
        tick(1);

        // Test 5: single-beat burst of -1
        send_beat(16'hFFFF, 1'b1);
        check("t5_sum",   32'(out_sum),    32'hFFFFFF);
        check("t5_count", 32'(out_count),  32'd1);
        check("t5_sum16", 32'(out_sum_16), 32'hFFFF);
        tick(1);

        // Test 6: reset mid-burst discards the partial sum
        send_beat(16'd100, 1'b0);
        send_beat(16'd200, 1'b0);
        #2 rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick(1);
        send_beat(16'd1, 1'b0);
        send_beat(16'd1, 1'b1);
        check("t6_sum",   32'(out_sum),   32'd2);
        check("t6_count", 32'(out_count), 32'd2);
        tick(1);

        // Test 6b: count saturates while the sum keeps accumulating
        for (int i = 0; i < 299; i++) send_beat(16'd1, 1'b0);
        send_beat(16'd1, 1'b1);
        check("t6_sat_count",   32'(out_count),    32'd255);
        check("t6_sat_sum",     32'(out_sum),      32'd300);
        check("t6_sat_sum16",   32'(out_sum_16),   32'd300);
        check("t6_sat_count16", 32'(out_count_16), 32'd255);
        tick(1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
